// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_pkg
// Description : RV32I opcode values, instruction field bit positions, the
//               canonical NOP word and the decoded-field bundle type shared
//               by the instruction encoder and its immediate packer.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

  // RV32I major opcodes
  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  // LSB positions of the register/funct fields inside a 32-bit word
  localparam int c_rd_lsb  = 7;
  localparam int c_f3_lsb  = 12;
  localparam int c_rs1_lsb = 15;
  localparam int c_rs2_lsb = 20;
  localparam int c_f7_lsb  = 25;

  // addi x0,x0,0 - emitted in place of anything with an unknown opcode
  localparam logic [31:0] c_nop = 32'h0000_0013;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  // Immediate-form shifts (slli/srli/srai) carry funct7 and a 5-bit shamt
  function automatic logic is_shift(input logic [6:0] op, input logic [2:0] f3);
    return (op == c_op_imm) && ((f3 == 3'b001) || (f3 == 3'b101));
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_imm_pack.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_imm_pack
// Description : Combinational immediate scatter for RV32I. Places the bits of
//               a full-width immediate where the opcode's format wants them
//               and flags values the format cannot represent.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_imm_pack
  import instr_encoder_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic        err,
  output logic        known
);

  logic w_fits12;
  logic w_fits13;
  logic w_fits21;

  // An N-bit signed field fits when every bit above the field's sign bit copies it
  assign w_fits12 = (imm[31:11] == {21{imm[11]}});
  assign w_fits13 = (imm[31:12] == {20{imm[12]}});
  assign w_fits21 = (imm[31:20] == {12{imm[20]}});

  // Scatter immediate bits per format and evaluate the matching range rule
  always_comb begin
    imm_bits = '0;
    err      = 1'b0;
    known    = 1'b1;
    case (opcode)
      c_op_r: begin
        // register-register: no immediate, nothing to check
      end
      c_op_imm: begin
        if (is_shift(opcode, funct3)) begin
          imm_bits[24:20] = imm[4:0];
          err             = |imm[31:5];
        end else begin
          imm_bits[31:20] = imm[11:0];
          err             = !w_fits12;
        end
      end
      c_op_load, c_op_jalr: begin
        imm_bits[31:20] = imm[11:0];
        err             = !w_fits12;
      end
      c_op_store: begin
        imm_bits[31:25] = imm[11:5];
        imm_bits[11:7]  = imm[4:0];
        err             = !w_fits12;
      end
      c_op_branch: begin
        imm_bits[31]    = imm[12];
        imm_bits[30:25] = imm[10:5];
        imm_bits[11:8]  = imm[4:1];
        imm_bits[7]     = imm[11];
        err             = !w_fits13 || imm[0];
      end
      c_op_lui, c_op_auipc: begin
        imm_bits[31:12] = imm[31:12];
        err             = |imm[11:0];
      end
      c_op_jal: begin
        imm_bits[31]    = imm[20];
        imm_bits[30:21] = imm[10:1];
        imm_bits[20]    = imm[11];
        imm_bits[19:12] = imm[19:12];
        err             = !w_fits21 || imm[0];
      end
      default: begin
        known = 1'b0;
        err   = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Two-stage RV32I instruction encoder. S1 captures decoded
//               fields, S2 holds the packed word and its error flag. Emits
//               each word with a wrapping instruction-memory byte address and
//               keeps a sticky error flag across handshaken words.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic        err_sticky,
  input  logic        clr
);

  localparam logic [31:0] c_last_addr = BASE_ADDR + 32'(4 * (DEPTH - 1));

  fields_t     r_s1;
  logic        r_s1_valid;
  logic        r_s2_valid;
  logic [31:0] r_s2_inst;
  logic        r_s2_err;
  logic [31:0] r_addr;
  logic        r_sticky;

  logic        w_advance;
  logic        w_out_fire;
  logic [31:0] w_imm_bits;
  logic        w_imm_err;
  logic        w_known;
  logic [31:0] w_regs;
  logic [31:0] w_inst;

  // Whole pipeline moves together whenever S2 is empty or being drained
  assign w_advance  = !r_s2_valid || out_ready;
  assign w_out_fire = r_s2_valid && out_ready;

  assign in_ready   = w_advance;
  assign out_valid  = r_s2_valid;
  assign out_inst   = r_s2_inst;
  assign out_err    = r_s2_err;
  assign out_addr   = r_addr;
  assign err_sticky = r_sticky;

  instr_encoder_imm_pack u_imm_pack (
    .opcode   (r_s1.opcode),
    .funct3   (r_s1.funct3),
    .imm      (r_s1.imm),
    .imm_bits (w_imm_bits),
    .err      (w_imm_err),
    .known    (w_known)
  );

  // Place the register/funct fields that the S1 opcode's format uses
  always_comb begin
    w_regs = '0;
    case (r_s1.opcode)
      c_op_r: begin
        w_regs[c_rd_lsb  +: 5] = r_s1.rd;
        w_regs[c_f3_lsb  +: 3] = r_s1.funct3;
        w_regs[c_rs1_lsb +: 5] = r_s1.rs1;
        w_regs[c_rs2_lsb +: 5] = r_s1.rs2;
        w_regs[c_f7_lsb  +: 7] = r_s1.funct7;
      end
      c_op_imm, c_op_load, c_op_jalr: begin
        w_regs[c_rd_lsb  +: 5] = r_s1.rd;
        w_regs[c_f3_lsb  +: 3] = r_s1.funct3;
        w_regs[c_rs1_lsb +: 5] = r_s1.rs1;
        if (is_shift(r_s1.opcode, r_s1.funct3)) begin
          w_regs[c_f7_lsb +: 7] = r_s1.funct7;
        end
      end
      c_op_store, c_op_branch: begin
        w_regs[c_f3_lsb  +: 3] = r_s1.funct3;
        w_regs[c_rs1_lsb +: 5] = r_s1.rs1;
        w_regs[c_rs2_lsb +: 5] = r_s1.rs2;
      end
      c_op_lui, c_op_auipc, c_op_jal: begin
        w_regs[c_rd_lsb +: 5] = r_s1.rd;
      end
      default: begin
        w_regs = '0;
      end
    endcase
  end

  assign w_inst = w_known ? (w_regs | w_imm_bits | {25'b0, r_s1.opcode}) : c_nop;

  // S1 captures the field bundle; its valid is the input handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_advance) begin
      r_s1_valid  <= in_valid;
      r_s1.opcode <= in_opcode;
      r_s1.rd     <= in_rd;
      r_s1.rs1    <= in_rs1;
      r_s1.rs2    <= in_rs2;
      r_s1.funct3 <= in_funct3;
      r_s1.funct7 <= in_funct7;
      r_s1.imm    <= in_imm;
    end
  end

  // S2 registers the packed word and its error; holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_inst  <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_advance) begin
      r_s2_valid <= r_s1_valid;
      r_s2_inst  <= w_inst;
      r_s2_err   <= w_imm_err;
    end
  end

  // Word address steps by 4 per emitted word and wraps at the window end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= BASE_ADDR;
    end else if (w_out_fire) begin
      r_addr <= (r_addr == c_last_addr) ? BASE_ADDR : r_addr + 32'd4;
    end
  end

  // Sticky error: clr takes priority over a simultaneous erroring handshake
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_sticky <= 1'b0;
    end else if (w_out_fire && r_s2_err) begin
      r_sticky <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder. Directed scenarios
//               followed by randomized traffic, all checked against a
//               behavioural encoding model and an in-order scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  localparam logic [31:0] c_base  = 32'h0000_0100;
  localparam int          c_depth = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic        err_sticky;
  logic        clr = 1'b0;

  instr_encoder #(.BASE_ADDR(c_base), .DEPTH(c_depth)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_addr   (out_addr),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .clr        (clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;
  int   acc_cnt  = 0;
  logic sticky_m = 1'b0;

  logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                            7'h37, 7'h17, 7'h6F, 7'h7F};
  logic [31:0] bnd [14] = '{32'h0000_07FF, 32'hFFFF_F800, 32'h0000_0800,
                            32'hFFFF_F7FF, 32'h0000_0FFE, 32'h0000_1000,
                            32'hFFFF_F000, 32'hFFFF_EFFE, 32'h000F_FFFE,
                            32'h0010_0000, 32'hFFF0_0000, 32'h0000_001F,
                            32'h0000_0020, 32'hFFEF_FFFE};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference encoder: range rules evaluated as signed integer bounds
  function automatic exp_t model(input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] imm);
    exp_t r;
    int   s;
    s = $signed(imm);
    case (op)
      7'h33: begin
        r.inst = {f7, rs2, rs1, f3, rd, op};
        r.err  = 1'b0;
      end
      7'h13, 7'h03, 7'h67: begin
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          r.inst = {f7, imm[4:0], rs1, f3, rd, op};
          r.err  = (imm > 32'd31);
        end else begin
          r.inst = {imm[11:0], rs1, f3, rd, op};
          r.err  = (s < -2048) || (s > 2047);
        end
      end
      7'h23: begin
        r.inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        r.err  = (s < -2048) || (s > 2047);
      end
      7'h63: begin
        r.inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        r.err  = (s < -4096) || (s > 4095) || (s % 2 != 0);
      end
      7'h37, 7'h17: begin
        r.inst = {imm[31:12], rd, op};
        r.err  = (imm % 32'd4096) != 0;
      end
      7'h6F: begin
        r.inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        r.err  = (s < -1048576) || (s > 1048575) || (s % 2 != 0);
      end
      default: begin
        r.inst = 32'h0000_0013;
        r.err  = 1'b1;
      end
    endcase
    return r;
  endfunction

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // One clock: monitor both handshakes mid-cycle, then check the sticky flag
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", out_inst, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        check("inst", out_inst, e.inst);
        check("err", {31'b0, out_err}, {31'b0, e.err});
        check("addr", out_addr, c_base + 32'(4 * (n_out % c_depth)));
        n_out++;
        if (e.err) sticky_m = 1'b1;
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    if (clr) sticky_m = 1'b0;
    check("sticky", {31'b0, err_sticky}, {31'b0, sticky_m});
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    clr      = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    n_out    = 0;
    sticky_m = 1'b0;
  endtask

  // Offer one bundle, then wait until it sits in S2
  task automatic single(input logic [6:0] op, input logic [31:0] imm);
    drive(op, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, imm);
    step();
    idle();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    int n0;
    // ---------------- reset state
    do_reset();
    do_reset();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", {31'b0, out_err}, 32'd0);
    check("rst_out_addr", out_addr, c_base);
    check("rst_sticky", {31'b0, err_sticky}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // ---------------- addi x1,x0,-1 latency
    out_ready = 1'b1;
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    step();
    idle();
    check("addi_n1_valid", {31'b0, out_valid}, 32'd0);
    step();
    check("addi_n2_valid", {31'b0, out_valid}, 32'd1);
    check("addi_inst", out_inst, 32'hFFF0_0093);
    check("addi_addr", out_addr, c_base);

    // ---------------- back-to-back sw / beq / lui
    drive(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    step();
    drive(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    step();
    check("sw_inst", out_inst, 32'h0020_A423);
    check("sw_addr", out_addr, c_base + 32'd4);
    drive(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    step();
    idle();
    check("beq_inst", out_inst, 32'hFE00_0EE3);
    check("beq_addr", out_addr, c_base + 32'd8);
    step();
    check("lui_inst", out_inst, 32'h1234_52B7);
    check("lui_addr", out_addr, c_base + 32'd12);
    step();

    // ---------------- error cases
    single(7'h6F, 32'd3);
    check("jal_odd_err", {31'b0, out_err}, 32'd1);
    step();
    check("jal_sticky", {31'b0, err_sticky}, 32'd1);
    single(7'h63, 32'd4096);
    check("br_range_err", {31'b0, out_err}, 32'd1);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_sticky", {31'b0, err_sticky}, 32'd0);
    single(7'h7F, 32'd0);
    check("unk_inst", out_inst, 32'h0000_0013);
    check("unk_err", {31'b0, out_err}, 32'd1);
    clr = 1'b1;   // clr coincides with the erroring handshake
    step();
    clr = 1'b0;
    check("clr_wins", {31'b0, err_sticky}, 32'd0);

    // ---------------- backpressure
    out_ready = 1'b0;
    a0 = acc_cnt;
    n0 = n_out;
    drive(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    step();
    drive(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    step();
    drive(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    step();
    step();
    step();
    check("bp_accepted", 32'(acc_cnt - a0), 32'd2);
    check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    check("bp_hold_inst", out_inst, 32'h0010_0193);
    check("bp_hold_addr", out_addr, c_base + 32'(4 * (n_out % c_depth)));
    out_ready = 1'b1;
    step();
    idle();
    for (int i = 0; i < 4; i++) step();
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_emitted", 32'(n_out - n0), 32'd3);

    // ---------------- reset with two words in flight
    drive(7'h33, 5'd7, 5'd8, 5'd9, 3'd0, 7'h20, 32'd0);
    step();
    drive(7'h13, 5'd4, 5'd4, 5'd0, 3'd0, 7'd0, 32'd5);
    step();
    idle();
    out_ready = 1'b0;
    check("inflight_valid", {31'b0, out_valid}, 32'd1);
    do_reset();
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_addr", out_addr, c_base);
    out_ready = 1'b1;
    single(7'h13, 32'd9);
    check("post_rst_addr", out_addr, c_base);
    check("post_rst_inst", out_inst, 32'h0090_0013);
    step();

    // ---------------- randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] imm;
      case ($urandom_range(0, 3))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2:       imm = bnd[$urandom_range(0, 13)];
        default: imm = $urandom & 32'hFFFF_F000;
      endcase
      if ($urandom_range(0, 9) < 7)
        drive(ops[$urandom_range(0, 10)], 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom), 7'($urandom), imm);
      else
        idle();
      out_ready = ($urandom_range(0, 9) < 7);
      clr       = ($urandom_range(0, 31) == 0);
      step();
    end
    clr = 1'b0;
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("final_drained", 32'(exp_q.size()), 32'd0);
    step();
    check("final_idle", {31'b0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
